// File: rtl/nor_chk_pkg.sv
// Shared types and constants for the NOR gate-block self-test checker.
// Gate vector positions follow the [0:7] ordering of the gate block output.
package nor_chk_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSample,
        StCheck,
        StDone
    } chk_state_t;

    // Number of (a,b) stimulus combinations per pass.
    localparam int unsigned NV = 4;

    localparam int unsigned IdxNotA = 0;
    localparam int unsigned IdxNotB = 1;
    localparam int unsigned IdxNor  = 2;
    localparam int unsigned IdxAnd  = 3;
    localparam int unsigned IdxOr   = 4;
    localparam int unsigned IdxNand = 5;
    localparam int unsigned IdxXnor = 6;
    localparam int unsigned IdxXor  = 7;

endpackage

// File: rtl/nor_gate_golden.sv
// Combinational golden model of the basic-gate block: maps (a,b) to the
// expected 8-bit gate vector.
module nor_gate_golden
    import nor_chk_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [0:7] y_o
);

    always_comb begin
        y_o          = '0;
        y_o[IdxNotA] = ~a_i;
        y_o[IdxNotB] = ~b_i;
        y_o[IdxNor]  = ~(a_i | b_i);
        y_o[IdxAnd]  = a_i & b_i;
        y_o[IdxOr]   = a_i | b_i;
        y_o[IdxNand] = ~(a_i & b_i);
        y_o[IdxXnor] = ~(a_i ^ b_i);
        y_o[IdxXor]  = a_i ^ b_i;
    end

endmodule

// File: rtl/nor_gate_checker.sv
// Self-test sequencer: walks all (a,b) combinations LOOPS times, samples the
// gate vector after SETTLE cycles and accumulates mismatches against golden.
module nor_gate_checker
    import nor_chk_pkg::*;
#(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned LOOPS  = 1,
    parameter int unsigned CW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [0:7]    y_in,
    output logic          a_out,
    output logic          b_out,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_count,
    output logic [0:7]    fail_mask
);

    localparam int unsigned ScW = $clog2(SETTLE + 1);
    localparam int unsigned LcW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    chk_state_t     state_q, state_d;
    logic [ScW-1:0] sc_q, sc_d;
    logic [1:0]     vi_q, vi_d;
    logic [LcW-1:0] lc_q, lc_d;
    logic [0:7]     y_q, y_d;
    logic           a_q, a_d;
    logic           b_q, b_d;
    logic           pass_q, pass_d;
    logic [CW-1:0]  err_q, err_d;
    logic [0:7]     mask_q, mask_d;

    logic [0:7]     golden;
    logic [0:7]     mism;

    nor_gate_golden u_golden (
        .a_i (vi_q[1]),
        .b_i (vi_q[0]),
        .y_o (golden)
    );

    assign mism = y_q ^ golden;

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        vi_d    = vi_q;
        lc_d    = lc_q;
        y_d     = y_q;
        a_d     = a_q;
        b_d     = b_q;
        pass_d  = pass_q;
        err_d   = err_q;
        mask_d  = mask_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d   = '0;
                    mask_d  = '0;
                    pass_d  = 1'b0;
                    vi_d    = '0;
                    lc_d    = '0;
                    sc_d    = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (sc_q == ScW'(SETTLE - 1)) begin
                    state_d = StSample;
                end else begin
                    sc_d = sc_q + ScW'(1);
                end
            end
            StSample: begin
                y_d     = y_in;
                state_d = StCheck;
            end
            StCheck: begin
                mask_d = mask_q | mism;
                if ((|mism) && (err_q != '1)) begin
                    err_d = err_q + CW'(1);
                end
                if (vi_q != 2'(NV - 1)) begin
                    vi_d    = vi_q + 2'd1;
                    sc_d    = '0;
                    a_d     = vi_d[1];
                    b_d     = vi_d[0];
                    state_d = StDrive;
                end else if (lc_q < LcW'(LOOPS - 1)) begin
                    lc_d    = lc_q + LcW'(1);
                    vi_d    = '0;
                    sc_d    = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = StDrive;
                end else begin
                    // Latch the verdict from the final count so it is valid alongside done.
                    pass_d  = (err_d == '0);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sc_q    <= '0;
            vi_q    <= '0;
            lc_q    <= '0;
            y_q     <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            vi_q    <= vi_d;
            lc_q    <= lc_d;
            y_q     <= y_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = (state_q == StDrive) || (state_q == StSample) || (state_q == StCheck);
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_nor_gate_checker.sv
// Bench for nor_gate_checker: two configurations run side by side against a
// cycle-level behavioural model, with optional faults injected into the gate block.
module tb_nor_gate_checker;

    localparam int S0 = 2;
    localparam int L0 = 1;
    localparam int C0 = 8;
    localparam int S1 = 1;
    localparam int L1 = 5;
    localparam int C1 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   fault = 0;
    int   cyc = 0;

    logic          a0, b0, busy0, done0, pass0;
    logic [C0-1:0] err0;
    logic [0:7]    mask0, gy0, y0;
    logic          a1, b1, busy1, done1, pass1;
    logic [C1-1:0] err1;
    logic [0:7]    mask1, gy1, y1;

    int tests = 0;
    int fails = 0;

    bit         act[2];
    int         k[2];
    bit         ea[2], eb[2], epass[2];
    int         eerr[2];
    logic [0:7] emask[2];
    int         fin_err[2];
    logic [0:7] fin_mask[2];
    int         acc_cyc[2], done_cyc[2];
    bit         done_seen[2];

    function automatic logic [0:7] ref_vec(int a, int b);
        logic [0:7] v;
        v[0] = (a == 0);
        v[1] = (b == 0);
        v[2] = (a + b == 0);
        v[3] = (a * b == 1);
        v[4] = (a + b > 0);
        v[5] = (a * b == 0);
        v[6] = (a == b);
        v[7] = (a != b);
        return v;
    endfunction

    function automatic logic [0:7] apply_fault(logic [0:7] y, int mode);
        logic [0:7] r;
        logic       t;
        r = y;
        case (mode)
            1: r[7] = 1'b0;
            2: begin t = r[3]; r[3] = r[4]; r[4] = t; end
            3: r = '1;
            default: ;
        endcase
        return r;
    endfunction

    nor_gate_golden u_gate0 (.a_i(a0), .b_i(b0), .y_o(gy0));
    nor_gate_golden u_gate1 (.a_i(a1), .b_i(b1), .y_o(gy1));
    assign y0 = apply_fault(gy0, fault);
    assign y1 = apply_fault(gy1, fault);

    nor_gate_checker #(.SETTLE(S0), .LOOPS(L0), .CW(C0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .y_in      (y0),
        .a_out     (a0),
        .b_out     (b0),
        .busy      (busy0),
        .done      (done0),
        .pass      (pass0),
        .err_count (err0),
        .fail_mask (mask0)
    );

    nor_gate_checker #(.SETTLE(S1), .LOOPS(L1), .CW(C1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .y_in      (y1),
        .a_out     (a1),
        .b_out     (b1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .err_count (err1),
        .fail_mask (mask1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Final error count and mask of a complete run, from the truth table alone.
    task automatic model_run(int l, int cwmax, int mode, output int e, output logic [0:7] m);
        logic [0:7] d;
        e = 0;
        m = '0;
        for (int p = 0; p < l; p++) begin
            for (int j = 0; j < 4; j++) begin
                d = apply_fault(ref_vec(j / 2, j % 2), mode) ^ ref_vec(j / 2, j % 2);
                m = m | d;
                if (d != '0 && e < cwmax) e++;
            end
        end
    endtask

    task automatic model_step(int d, int s, int l, int cwmax, logic a, logic b, logic bsy,
                              logic dn, logic ps, int err, logic [0:7] mask);
        int total;
        int j;
        string n;
        total = 4 * l * (s + 2);
        n = $sformatf("dut%0d", d);
        if (!rst_n) begin
            chk({n, ".rst_a"}, int'(a), 0);
            chk({n, ".rst_b"}, int'(b), 0);
            chk({n, ".rst_busy"}, int'(bsy), 0);
            chk({n, ".rst_done"}, int'(dn), 0);
            chk({n, ".rst_pass"}, int'(ps), 0);
            chk({n, ".rst_err"}, err, 0);
            chk({n, ".rst_mask"}, int'(mask), 0);
            act[d] = 0; ea[d] = 0; eb[d] = 0; epass[d] = 0; eerr[d] = 0; emask[d] = '0;
            return;
        end
        if (act[d] && k[d] <= total) begin
            j = ((k[d] - 1) / (s + 2)) % 4;
            chk({n, ".run_a"}, int'(a), j / 2);
            chk({n, ".run_b"}, int'(b), j % 2);
            chk({n, ".run_busy"}, int'(bsy), 1);
            chk({n, ".run_done"}, int'(dn), 0);
            chk({n, ".run_pass"}, int'(ps), 0);
        end else if (act[d]) begin
            ea[d] = 1; eb[d] = 1;
            eerr[d] = fin_err[d];
            emask[d] = fin_mask[d];
            epass[d] = (fin_err[d] == 0);
            chk({n, ".end_a"}, int'(a), 1);
            chk({n, ".end_b"}, int'(b), 1);
            chk({n, ".end_busy"}, int'(bsy), 0);
            chk({n, ".end_done"}, int'(dn), 1);
            chk({n, ".end_err"}, err, eerr[d]);
            chk({n, ".end_mask"}, int'(mask), int'(emask[d]));
            chk({n, ".end_pass"}, int'(ps), int'(epass[d]));
            done_seen[d] = 1;
            done_cyc[d] = cyc - acc_cyc[d];
        end else begin
            chk({n, ".idle_a"}, int'(a), int'(ea[d]));
            chk({n, ".idle_b"}, int'(b), int'(eb[d]));
            chk({n, ".idle_busy"}, int'(bsy), 0);
            chk({n, ".idle_done"}, int'(dn), 0);
            chk({n, ".idle_err"}, err, eerr[d]);
            chk({n, ".idle_mask"}, int'(mask), int'(emask[d]));
            chk({n, ".idle_pass"}, int'(ps), int'(epass[d]));
        end
        if (act[d]) begin
            if (k[d] == total + 1) act[d] = 0;
            else k[d]++;
        end else if (start) begin
            act[d] = 1;
            k[d] = 1;
            acc_cyc[d] = cyc;
            done_seen[d] = 0;
            eerr[d] = 0; emask[d] = '0; epass[d] = 0;
            model_run(l, cwmax, fault, fin_err[d], fin_mask[d]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step(0, S0, L0, (1 << C0) - 1, a0, b0, busy0, done0, pass0, int'(err0), mask0);
            model_step(1, S1, L1, (1 << C1) - 1, a1, b1, busy1, done1, pass1, int'(err1), mask1);
        end
    end

    task automatic run(int mode, bit repulse);
        @(posedge clk); #1 fault = mode; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (repulse) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        for (int i = 0; i < 300 && !(done_seen[0] && done_seen[1]); i++) @(posedge clk);
        chk("run_completed", int'(done_seen[0] && done_seen[1]), 1);
        chk("done_cycle0", done_cyc[0], 17);
        chk("done_cycle1", done_cyc[1], 61);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run(0, 0);
        chk("clean_pass0", int'(pass0), 1);
        chk("clean_err0", int'(err0), 0);
        chk("clean_model_err1", fin_err[1], 0);

        run(1, 0);
        chk("xor0_model_err", fin_err[0], 2);
        chk("xor0_model_mask", int'(fin_mask[0]), 8'h01);
        chk("xor0_pass", int'(pass0), 0);
        chk("xor1_err", int'(err1), 10);

        run(2, 0);
        chk("swap1_model_err", fin_err[1], 10);
        chk("swap1_model_mask", int'(fin_mask[1]), 8'h18);
        chk("swap0_err", int'(err0), 2);

        run(3, 0);
        chk("ones1_err_sat", int'(err1), 15);
        chk("ones1_mask", int'(mask1), 8'hff);
        chk("ones0_err", int'(err0), 4);
        chk("ones1_pass", int'(pass1), 0);

        run(0, 1);
        chk("repulse_pass1", int'(pass1), 1);

        // Abort a run with reset and confirm outputs clear without a clock edge.
        @(posedge clk); #1 fault = 0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("async_busy0", int'(busy0), 0);
        chk("async_a0", int'(a0), 0);
        chk("async_busy1", int'(busy1), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        chk("abort_no_done0", int'(done_seen[0]), 0);
        repeat (3) @(posedge clk);

        run(0, 0);
        chk("after_abort_pass0", int'(pass0), 1);
        chk("after_abort_pass1", int'(pass1), 1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nor_gate_checker.md
# nor_gate_checker

Self-test sequencer that drives the two inputs of the NOR-built basic-gate block and checks its 8-bit gate vector against a golden truth table. On `start` it walks all four (a,b) combinations, optionally for several loops. For each one it waits a settle interval, samples the gate vector and accumulates mismatches. It is the stimulus-and-check stage wrapped around the gate block in the day-level top: it feeds `a`/`b` and consumes `y`.

## Interface
- `SETTLE`, default 2: cycles `a_out`/`b_out` are held before sampling; must be ≥1.
- `LOOPS`, default 1: number of full 4-vector passes per run; must be ≥1.
- `CW`, default 8: width of the error counter.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled only in IDLE.
- `y_in` in [0:7]: gate vector from the DUT, in order NOT a, NOT b, NOR, AND, OR, NAND, XNOR, XOR.
- `a_out` out 1: stimulus a, registered.
- `b_out` out 1: stimulus b, registered.
- `busy` out 1: high from the cycle after start acceptance until DONE.
- `done` out 1: one-cycle pulse at run end.
- `pass` out 1: `err_count==0` at run end; held until the next accepted start.
- `err_count` out CW: vectors with ≥1 mismatching bit; saturates at 2^CW−1.
- `fail_mask` out [0:7]: sticky OR of mismatch bits, same ordering as `y_in`.

## Operation
- States: IDLE, DRIVE, SAMPLE, CHECK, DONE.
- IDLE, `start`=1:
  - clear `err_count`, `fail_mask`, `pass`, vector index `vi`=0 and loop count `lc`=0;
  - go to DRIVE.
- DRIVE:
  - `a_out`=`vi[1]`, `b_out`=`vi[0]`;
  - stay for exactly SETTLE cycles (settle counter), then go to SAMPLE.
- SAMPLE: register `y_in` into `y_q`; go to CHECK.
- CHECK:
  - compute `m = y_q ^ golden(vi)`;
  - `fail_mask |= m`;
  - if `|m`, increment `err_count` (saturating).
  - If `vi`<3: `vi++` and go to DRIVE.
  - Else if `lc`<LOOPS−1: `lc++`, `vi`=0, go to DRIVE.
  - Else go to DONE.
- DONE: `done`=1 for this one cycle; `pass` latched; go to IDLE.
- Golden vector for (a,b) is {~a, ~b, ~(a|b), a&b, a|b, ~(a&b), ~(a^b), a^b}.
- `start` while `busy` is ignored and not queued. `start` held high in IDLE after DONE begins a new run.
- `a_out`/`b_out` hold their last values in SAMPLE, CHECK, DONE and IDLE.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_mask`=0, state IDLE.
- Reset asserted mid-run aborts immediately. No `done` pulse is produced and all outputs take their reset values.
- `start` accepted at edge T → DRIVE at T+1 with `a_out`=`b_out`=0 and `busy`=1.
- Each vector takes SETTLE+2 cycles.
- `done` is high at T+1+4·LOOPS·(SETTLE+2). `busy` falls that same cycle.
- `y_in` is sampled SETTLE cycles after the stimulus changes. The DUT is combinational, so SETTLE=1 is sufficient.
- Saturation: at 2^CW−1, `err_count` stays put. `fail_mask` still updates.

## Structure
- Package `nor_chk_pkg`:
  - state enum `chk_state_t`;
  - constant `NV=4`;
  - index constants for the 8 gate positions.
- Sub-module `nor_gate_golden`: combinational (a,b) → [0:7] expected vector. The bench reuses it as its reference.
- Counters: settle (≥ $clog2(SETTLE+1) bits), `vi` (2 bits), `lc` (≥ $clog2(LOOPS) bits).

## Test plan
- Correct DUT, SETTLE=2, LOOPS=1, start at cycle 0 → `done` at cycle 17, `pass`=1, `err_count`=0, `fail_mask`=0. `a_out`/`b_out` sequence is 00, 01, 10, 11, each held 4 cycles.
- DUT with XOR output stuck at 0 → `err_count`=2 (vectors 01, 10), `fail_mask`=0000_0001 (bit 7 only), `pass`=0.
- DUT with AND/OR outputs swapped, LOOPS=3 → `err_count`=6, `fail_mask` bits 3 and 4 set, `done` at cycle 1+12·4=49.
- All-ones `y_in`, CW=4, LOOPS=5 → `err_count` saturates at 15, `fail_mask`=all ones.
- `start` pulsed again in cycle 5 of a run → ignored; `done` timing unchanged.
- `rst_n` low in cycle 9 of a run → all outputs 0 asynchronously, no `done`. A start after release runs a full clean pass.
